// File: rtl/greyscaler_pkg.sv
// rtl/greyscaler_pkg.sv - mode encoding and fixed-point coefficients for the greyscaler
package greyscaler_pkg;

    typedef enum logic [1:0] {
        GS_PASS   = 2'b00,
        GS_LUMA   = 2'b01,
        GS_AVG    = 2'b10,
        GS_THRESH = 2'b11
    } gs_mode_t;

    localparam int COEF_R   = 77;
    localparam int COEF_G   = 150;
    localparam int COEF_B   = 29;
    localparam int COEF_AVG = 86;
    localparam int ROUND    = 128;
    localparam int SHIFT    = 8;

endpackage

// File: rtl/greyscaler_pixel.sv
// rtl/greyscaler_pixel.sv - two-stage per-pixel luma/average/threshold datapath
module greyscaler_pixel
    import greyscaler_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [3*CW-1:0] pix,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   thr,
    output logic [3*CW-1:0] pix_out
);

    localparam int PW = CW + 10;
    localparam logic [CW-1:0] MAX = {CW{1'b1}};

    logic [PW-1:0]   r, g, b;
    logic [PW-1:0]   luma_next, avg_next;
    logic [PW-1:0]   luma_sum, avg_sum;
    logic [3*CW-1:0] raw;
    logic [CW-1:0]   luma, avg, bin;
    logic [3*CW-1:0] result;
    logic            unused_bits;

    assign r = PW'(pix[2*CW +: CW]);
    assign g = PW'(pix[CW +: CW]);
    assign b = PW'(pix[0 +: CW]);

    assign luma_next = PW'(COEF_R) * r + PW'(COEF_G) * g + PW'(COEF_B) * b + PW'(ROUND);
    assign avg_next  = PW'(COEF_AVG) * (r + g + b) + PW'(ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_sum <= '0;
            avg_sum  <= '0;
            raw      <= '0;
        end else if (en) begin
            luma_sum <= luma_next;
            avg_sum  <= avg_next;
            raw      <= pix;
        end
    end

    // Luma never exceeds MAX; the average can reach MAX+2 and must saturate.
    assign luma = luma_sum[SHIFT +: CW];
    assign avg  = (|avg_sum[PW-1:SHIFT+CW]) ? MAX : avg_sum[SHIFT +: CW];
    assign bin  = (luma >= thr) ? MAX : '0;
    assign unused_bits = ^{luma_sum[PW-1:SHIFT+CW], luma_sum[SHIFT-1:0], avg_sum[SHIFT-1:0]};

    always_comb begin
        result = raw;
        case (mode)
            GS_LUMA:   result = {3{luma}};
            GS_AVG:    result = {3{avg}};
            GS_THRESH: result = {3{bin}};
            default:   result = raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out <= '0;
        end else if (en) begin
            pix_out <= result;
        end
    end

endmodule

// File: rtl/axis_greyscaler_v2.sv
// rtl/axis_greyscaler_v2.sv - AXI4-Stream multi-pixel greyscaler with per-frame mode latch
module axis_greyscaler_v2
    import greyscaler_pkg::*;
#(
    parameter int CHANNEL_WIDTH   = 8,
    parameter int PIXELS_PER_BEAT = 1
) (
    input  logic                                         s_axis_aclk,
    input  logic                                         s_axis_aresetn,
    input  logic [3*CHANNEL_WIDTH*PIXELS_PER_BEAT-1:0]   S_AXIS_TDATA,
    input  logic                                         S_AXIS_TVALID,
    output logic                                         S_AXIS_TREADY,
    input  logic                                         S_AXIS_VIDEO_TUSER,
    input  logic                                         S_AXIS_VIDEO_TLAST,
    output logic [3*CHANNEL_WIDTH*PIXELS_PER_BEAT-1:0]   M_AXIS_TDATA,
    output logic                                         M_AXIS_TVALID,
    input  logic                                         M_AXIS_TREADY,
    output logic                                         M_AXIS_VIDEO_TUSER,
    output logic                                         M_AXIS_VIDEO_TLAST,
    input  logic [1:0]                                   mode,
    input  logic [CHANNEL_WIDTH-1:0]                     threshold,
    output logic [1:0]                                   active_mode,
    output logic [15:0]                                  frame_count
);

    localparam int CW         = CHANNEL_WIDTH;
    localparam int PIX_W      = 3 * CW;
    localparam int DATA_WIDTH = PIX_W * PIXELS_PER_BEAT;

    logic          rst_done;
    logic          adv, accept, sof;
    logic [CW-1:0] active_thr;
    logic [1:0]    eff_mode;
    logic [CW-1:0] eff_thr;
    logic          s1_valid, s1_user, s1_last;
    logic [1:0]    s1_mode;
    logic [CW-1:0] s1_thr;
    logic          s2_valid, s2_user, s2_last;

    assign adv           = !s2_valid || M_AXIS_TREADY;
    assign S_AXIS_TREADY = adv && rst_done;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign sof           = accept && S_AXIS_VIDEO_TUSER;

    // The SOF beat itself already uses the freshly requested settings.
    assign eff_mode = sof ? mode : active_mode;
    assign eff_thr  = sof ? threshold : active_thr;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rst_done    <= 1'b0;
            active_mode <= GS_PASS;
            active_thr  <= '0;
            frame_count <= '0;
        end else begin
            rst_done <= 1'b1;
            if (sof) begin
                active_mode <= mode;
                active_thr  <= threshold;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s1_valid <= 1'b0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= GS_PASS;
            s1_thr   <= '0;
            s2_valid <= 1'b0;
            s2_user  <= 1'b0;
            s2_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            s1_user  <= accept && S_AXIS_VIDEO_TUSER;
            s1_last  <= accept && S_AXIS_VIDEO_TLAST;
            s1_mode  <= eff_mode;
            s1_thr   <= eff_thr;
            s2_valid <= s1_valid;
            s2_user  <= s1_user;
            s2_last  <= s1_last;
        end
    end

    assign M_AXIS_TVALID      = s2_valid;
    assign M_AXIS_VIDEO_TUSER = s2_user;
    assign M_AXIS_VIDEO_TLAST = s2_last;

    // Stage-1 mode/threshold registers feed every pixel's stage-2 mux.
    for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : g_pix
        greyscaler_pixel #(
            .CW (CW)
        ) u_pixel (
            .clk     (s_axis_aclk),
            .rst_n   (s_axis_aresetn),
            .en      (adv),
            .pix     (S_AXIS_TDATA[p*PIX_W +: PIX_W]),
            .mode    (s1_mode),
            .thr     (s1_thr),
            .pix_out (M_AXIS_TDATA[p*PIX_W +: PIX_W])
        );
    end

    logic [DATA_WIDTH-1:0] unused_width_probe;
    assign unused_width_probe = M_AXIS_TDATA;

endmodule

// File: tb/tb_axis_greyscaler_v2.sv
// tb/tb_axis_greyscaler_v2.sv - randomized scoreboard bench for axis_greyscaler_v2
module tb_axis_greyscaler_v2;

    localparam int CW  = 8;
    localparam int PPB = 2;
    localparam int DW  = 3 * CW * PPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tuser, s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tuser, m_tlast;
    logic [1:0]    mode, active_mode;
    logic [CW-1:0] threshold;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    axis_greyscaler_v2 #(
        .CHANNEL_WIDTH   (CW),
        .PIXELS_PER_BEAT (PPB)
    ) dut (
        .s_axis_aclk        (clk),
        .s_axis_aresetn     (rst_n),
        .S_AXIS_TDATA       (s_tdata),
        .S_AXIS_TVALID      (s_tvalid),
        .S_AXIS_TREADY      (s_tready),
        .S_AXIS_VIDEO_TUSER (s_tuser),
        .S_AXIS_VIDEO_TLAST (s_tlast),
        .M_AXIS_TDATA       (m_tdata),
        .M_AXIS_TVALID      (m_tvalid),
        .M_AXIS_TREADY      (m_tready),
        .M_AXIS_VIDEO_TUSER (m_tuser),
        .M_AXIS_VIDEO_TLAST (m_tlast),
        .mode               (mode),
        .threshold          (threshold),
        .active_mode        (active_mode),
        .frame_count        (frame_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic [1:0]    md;
        logic [CW-1:0] thr;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        int            cyc;
    } exp_t;

    beat_t         stim_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] rx_q[$];
    logic          rx_u[$];
    logic          rx_l[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [1:0]    am_m;
    logic [CW-1:0] at_m;
    int            fc_m;
    bit            acc_flag, held_v;
    logic [DW-1:0] held_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_pixel(input logic [1:0] md, input logic [7:0] thr,
                                                input logic [23:0] px);
        int r, g, b, y, a, v;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        a = (86 * (r + g + b) + 128) / 256;
        if (a > 255) a = 255;
        case (md)
            2'd0:    return px;
            2'd1:    v = y;
            2'd2:    v = a;
            default: v = (y >= int'(thr)) ? 255 : 0;
        endcase
        return {v[7:0], v[7:0], v[7:0]};
    endfunction

    function automatic logic [23:0] rnd_px();
        logic [31:0] t;
        t = $urandom;
        return t[23:0];
    endfunction

    task automatic push(input logic [23:0] p0, input logic [23:0] p1, input logic u, input logic l,
                        input logic [1:0] md, input logic [7:0] th);
        beat_t bt;
        bt.data = {p1, p0};
        bt.user = u;
        bt.last = l;
        bt.md   = md;
        bt.thr  = th;
        stim_q.push_back(bt);
    endtask

    task automatic model_accept(input beat_t bt);
        exp_t e;
        if (bt.user) begin
            am_m = bt.md;
            at_m = bt.thr;
            fc_m++;
        end
        e.data = {model_pixel(am_m, at_m, bt.data[47:24]), model_pixel(am_m, at_m, bt.data[23:0])};
        e.user = bt.user;
        e.last = bt.last;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    // rmode: 0 = always ready, 1 = random backpressure, 2 = never ready
    task automatic cycle(input int rmode);
        exp_t e;
        @(negedge clk);
        if (acc_flag) begin
            s_tvalid = 1'b0;
            acc_flag = 1'b0;
        end
        if (held_v) begin
            check("hold_valid", m_tvalid, 1'b1);
            check("hold_data", m_tdata, held_d);
        end
        m_tready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (!s_tvalid && stim_q.size() != 0 && (rmode != 1 || $urandom_range(0, 3) != 0)) begin
            s_tdata   = stim_q[0].data;
            s_tuser   = stim_q[0].user;
            s_tlast   = stim_q[0].last;
            mode      = stim_q[0].md;
            threshold = stim_q[0].thr;
            s_tvalid  = 1'b1;
        end
        #1;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", m_tvalid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("data", m_tdata, e.data);
                check("tuser", m_tuser, e.user);
                check("tlast", m_tlast, e.last);
                if (rmode == 0) check("latency", cyc - e.cyc, 2);
            end
            rx_q.push_back(m_tdata);
            rx_u.push_back(m_tuser);
            rx_l.push_back(m_tlast);
        end
        held_v = m_tvalid && !m_tready;
        held_d = m_tdata;
        if (s_tvalid && s_tready) begin
            model_accept(stim_q.pop_front());
            acc_flag = 1'b1;
        end
        cyc++;
    endtask

    task automatic run(input int rmode, input int bound);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || acc_flag) && n < bound) begin
            cycle(rmode);
            n++;
        end
        check("drain", stim_q.size() + exp_q.size(), 0);
        check("active_mode", active_mode, am_m);
        check("frame_count", frame_count, fc_m);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_u.delete();
        rx_l.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        acc_flag = 1'b0;
        held_v   = 1'b0;
        #1;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, '0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_active_mode", active_mode, 2'b00);
        check("rst_frame_count", frame_count, 16'd0);
        am_m = 2'b00;
        at_m = '0;
        fc_m = 0;
        stim_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_s_tready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        check("ready_after_release", s_tready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int users;
        logic [23:0] px_a;
        rst_n     = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tuser   = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        mode      = 2'b00;
        threshold = '0;
        acc_flag  = 1'b0;
        held_v    = 1'b0;
        do_reset();

        // luma on white then black, first SOF
        clear_rx();
        push(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 2'd1, 8'd0);
        push(24'h000000, 24'h000000, 1'b0, 1'b1, 2'd1, 8'd0);
        run(0, 50);
        check("A_white", rx_q.size() > 0 ? rx_q[0] : '1, 48'hFFFFFF_FFFFFF);
        check("A_black", rx_q.size() > 1 ? rx_q[1] : '1, 48'h000000_000000);

        // channel average with saturation
        clear_rx();
        push(24'h0A141E, 24'hFFFFFF, 1'b1, 1'b1, 2'd2, 8'd0);
        run(0, 50);
        check("B_avg", rx_q.size() > 0 ? rx_q[0] : '0, 48'hFFFFFF_141414);

        // threshold boundary at 100
        clear_rx();
        push(24'h646464, 24'h636363, 1'b1, 1'b1, 2'd3, 8'd100);
        run(0, 50);
        check("C_thresh", rx_q.size() > 0 ? rx_q[0] : '1, 48'h000000_FFFFFF);

        // mid-frame mode change is ignored until the next SOF
        clear_rx();
        push(24'h0A141E, 24'h0A141E, 1'b1, 1'b0, 2'd1, 8'd0);
        push(24'h0A141E, 24'h0A141E, 1'b0, 1'b0, 2'd0, 8'd0);
        push(24'h123456, 24'h789ABC, 1'b0, 1'b1, 2'd0, 8'd0);
        push(24'h0A141E, 24'hC0FFEE, 1'b1, 1'b0, 2'd0, 8'd0);
        push(24'h0A141E, 24'h0A141E, 1'b0, 1'b1, 2'd1, 8'd0);
        run(0, 80);
        check("D_luma_kept", rx_q.size() > 1 ? rx_q[1] : '0, 48'h121212_121212);
        check("D_sof_pass", rx_q.size() > 3 ? rx_q[3] : '0, 48'hC0FFEE_0A141E);
        check("D_after_pass", rx_q.size() > 4 ? rx_q[4] : '0, 48'h0A141E_0A141E);

        // 4x3 frame under random backpressure
        do_reset();
        clear_rx();
        for (int i = 0; i < 6; i++)
            push(rnd_px(), rnd_px(), i == 0, (i % 2) == 1, 2'($urandom_range(0, 3)), 8'($urandom));
        run(1, 400);
        check("E_beats", rx_q.size(), 6);
        users = 0;
        foreach (rx_u[i]) users += int'(rx_u[i]);
        check("E_tuser_count", users, 1);
        foreach (rx_l[i]) check("E_tlast_pattern", rx_l[i], (i % 2) == 1);
        check("E_frame_count", frame_count, 16'd1);

        // back-to-back random frames, random mode requests on every beat
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 6; i++) begin
                px_a = rnd_px();
                push(px_a, ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : rnd_px(), i == 0,
                     (i % 2) == 1, 2'($urandom_range(0, 3)), 8'($urandom));
            end
        run(1, 2000);

        // reset with two beats in flight
        clear_rx();
        push(rnd_px(), rnd_px(), 1'b1, 1'b0, 2'd1, 8'd0);
        push(rnd_px(), rnd_px(), 1'b0, 1'b1, 2'd1, 8'd0);
        for (int n = 0; n < 20 && stim_q.size() != 0; n++) cycle(2);
        @(negedge clk);
        check("F_inflight_valid", m_tvalid, 1'b1);
        do_reset();
        for (int n = 0; n < 10; n++) cycle(0);
        check("F_no_output", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
